// File: rtl/alu_issue_ctl.sv
// alu_issue_ctl
// Sequential initiator for the 2x2 ALU datapath. Accepts register-addressed
// ALU commands over a valid/ready handshake and reads operands from an
// internal 16x32 register file. It drives op/a/b to an external combinational
// ALU, latches q0/q1/st, writes the results back and keeps the architectural
// flags register.
//
// Ports:
//   clk, rst                  clock (rising edge), async active-high reset
//   cmd_valid/cmd_ready       command handshake (ready only in IDLE)
//   cmd_op/ra/rb/rd/rd2       opcode, source regs, destinations (rd2 for MUL q1)
//   alu_op/alu_a/alu_b        registered operation presented to the ALU
//   alu_q0/alu_q1/alu_st      ALU results and status {N,Z,C,V}
//   ld_en/ld_addr/ld_data     external register load port (any state)
//   rd_addr/rd_data           combinational debug read port
//   flags                     architectural flags {N,Z,C,V}
//   done, err                 one-cycle pulses: command retired / opcode rejected
//
// Optional feature macro: ZERO_REG_EN
//   When defined, R0 reads as zero everywhere and writes to it are dropped.

module alu_issue_ctl #(
  parameter int         NREGS  = 16,
  parameter logic [7:0] OP_MAX = 8'h11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_op,
  input  logic [3:0]  cmd_ra,
  input  logic [3:0]  cmd_rb,
  input  logic [3:0]  cmd_rd,
  input  logic [3:0]  cmd_rd2,
  output logic [7:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_q0,
  input  logic [31:0] alu_q1,
  input  logic [3:0]  alu_st,
  input  logic        ld_en,
  input  logic [3:0]  ld_addr,
  input  logic [31:0] ld_data,
  input  logic [3:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic [3:0]  flags,
  output logic        done,
  output logic        err
);

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_MUL = 8'h04;

`ifdef ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, EXEC, WB, WBH} state_t;

  state_t      state, state_nx;
  logic [31:0] regs [NREGS];
  logic [3:0]  rd_q, rd2_q;
  logic [31:0] q0_l, q1_l;
  logic [3:0]  st_l;
  logic [3:0]  flags_q;
  logic        done_q, err_q;
  logic        accept, reject;
  logic [31:0] opa_rd, opb_rd;

  // Register file reads, with R0 forced to zero when the zero register is on.
  always_comb begin
    opa_rd  = regs[cmd_ra];
    opb_rd  = regs[cmd_rb];
    rd_data = regs[rd_addr];
    if (ZERO_REG && cmd_ra == 4'd0)  opa_rd  = 32'h0;
    if (ZERO_REG && cmd_rb == 4'd0)  opb_rd  = 32'h0;
    if (ZERO_REG && rd_addr == 4'd0) rd_data = 32'h0;
  end

  // Next-state logic. An out-of-range opcode is consumed in IDLE without
  // leaving it, so the rejection costs a single cycle.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    reject   = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_op > OP_MAX) begin
            reject = 1'b1;
          end else begin
            accept   = 1'b1;
            state_nx = EXEC;
          end
        end
      end
      EXEC:    state_nx = WB;
      WB:      state_nx = (alu_op == OP_MUL) ? WBH : IDLE;
      WBH:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign cmd_ready = (state == IDLE);
  assign flags     = flags_q;
  assign done      = done_q;
  assign err       = err_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Command capture, result latching, flags and the done/err pulses.
  // alu_op doubles as the opcode of the command in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_op  <= 8'h00;
      alu_a   <= 32'h0;
      alu_b   <= 32'h0;
      rd_q    <= 4'd0;
      rd2_q   <= 4'd0;
      q0_l    <= 32'h0;
      q1_l    <= 32'h0;
      st_l    <= 4'h0;
      flags_q <= 4'h0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        alu_op <= cmd_op;
        alu_a  <= opa_rd;
        alu_b  <= opb_rd;
        rd_q   <= cmd_rd;
        rd2_q  <= cmd_rd2;
      end
      if (state == EXEC) begin
        q0_l <= alu_q0;
        q1_l <= alu_q1;
        st_l <= alu_st;
      end
      if (state == WB && alu_op != OP_NOP) flags_q <= st_l;
      done_q <= (state == WB && alu_op != OP_MUL) || (state == WBH);
      err_q  <= reject;
    end
  end

  // Register file writes. Writebacks are placed after the external load so
  // they take priority on an address collision; WB and WBH never overlap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= 32'h0;
    end else begin
      if (ld_en && !(ZERO_REG && ld_addr == 4'd0))
        regs[ld_addr] <= ld_data;
      if (state == WB && !(ZERO_REG && rd_q == 4'd0))
        regs[rd_q] <= q0_l;
      if (state == WBH && !(ZERO_REG && rd2_q == 4'd0))
        regs[rd2_q] <= q1_l;
    end
  end

endmodule

// File: doc/alu_issue_ctl.md
Name: alu_issue_ctl

Overview:
Sequential initiator for the 2x2 ALU datapath. It accepts register-addressed ALU commands over a valid/ready handshake and reads operands from an internal 16x32 register file. It drives op/a/b to an external ALU instance, captures q0/q1/st, writes results back, and maintains the architectural flags register. It sits between the instruction decode stage and the combinational ALU.

Parameters:
NREGS, 16, register file depth (address width 4; fixed at 16)
OP_MAX, 8'h11, highest valid ALU opcode; opcodes above it are rejected

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  controller can accept (high only in IDLE)
cmd_op  in  8  ALU opcode (00 NOP .. 11 XNOR, 04 MUL)
cmd_ra  in  4  source register A
cmd_rb  in  4  source register B
cmd_rd  in  4  destination for q0
cmd_rd2  in  4  destination for q1 (MUL only)
alu_op  out  8  opcode to ALU
alu_a  out  32  operand A to ALU
alu_b  out  32  operand B to ALU
alu_q0  in  32  ALU result low
alu_q1  in  32  ALU result high
alu_st  in  4  ALU status {N,Z,C,V}, bit0=V
ld_en  in  1  external register load strobe
ld_addr  in  4  load address
ld_data  in  32  load data
rd_addr  in  4  debug read address
rd_data  out  32  debug read data (combinational)
flags  out  4  architectural flags {N,Z,C,V}
done  out  1  one-cycle pulse, command retired
err  out  1  one-cycle pulse, opcode rejected

Behaviour:
- Reset (async, rst=1): state=IDLE; all 16 registers=0; flags=0; alu_op=8'h00; alu_a=alu_b=0; result latches=0; done=err=0. cmd_ready=1 while in IDLE, including during reset. Reset mid-command abandons it; no writeback occurs.
- States: IDLE, EXEC, WB, WBH.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready:
  - Register alu_op=cmd_op, alu_a=R[ra], alu_b=R[rb], rd, rd2.
  - Go to EXEC.
  - If cmd_op>OP_MAX: do not change alu_op/alu_a/alu_b; pulse err next cycle; stay IDLE; no write; flags unchanged.
- EXEC: alu_* stable; capture alu_q0, alu_q1, alu_st into result latches at the end of the cycle; go to WB.
- WB: write q0 to R[rd]. Flags update from latched st for every op except NOP (00), which leaves flags unchanged.
  - If op==04: go to WBH.
  - Otherwise: go to IDLE and pulse done in the following cycle.
- WBH: write q1 to R[rd2]; go to IDLE; pulse done in the following cycle. If rd2==rd, the q1 write wins.
- Latency from the accept edge: non-MUL, done high on cycle 3; MUL, done high on cycle 4. Throughput is one command per 3 cycles (4 for MUL).
- alu_op/alu_a/alu_b hold their last values in IDLE.
- Operand read at accept is read-before-write: a same-cycle ld_en to ra/rb is not seen.
- ld_en is honoured in any state. If ld_en and a WB/WBH write target the same address in the same cycle, the writeback wins. Different addresses both write.
- rd_data=R[rd_addr], combinational; reflects a write on the cycle after it.
- cmd_* are sampled only on accept; changes at other times are ignored.

Optional Feature:
ZERO_REG_EN: when defined, R0 reads as 32'h0 everywhere (operands, rd_data), and ld/writeback to address 0 are discarded. Flags still update from st. When undefined, R0 is an ordinary register.

Test Plan:
- ld R1=5, R2=7; cmd ADD ra=1 rb=2 rd=3 -> done 3 cycles after accept; R3=12; flags=4'b0000.
- ld R1=32'h10000, R2=32'h10000; MUL ra=1 rb=2 rd=4 rd2=5 -> R4=0, R5=1, flags=4'b0010, done on cycle 4.
- cmd_op=8'h20 with cmd_valid -> err pulses one cycle, cmd_ready stays 1, registers and flags unchanged, done never asserts.
- ADD with rd=6 while ld_en addr=6 data=32'hDEAD lands in the WB cycle -> R6=ADD result; repeat with ld addr=7 -> R6=result and R7=32'hDEAD.
- Assert rst during EXEC of SUB rd=8 -> R8=0, flags=0, state IDLE, cmd_ready=1, done=0; a new ADD afterwards completes normally.
- With ZERO_REG_EN: ld R0=32'hFFFF_FFFF, then ADD ra=0 rb=0 rd=9 -> R9=0, rd_data(addr 0)=0, flags Z=1.
